id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_if.sv | 63 ++++++
 rtl/id_stage.sv | 213 +++++++++++++++++++++
 tb/tb_id_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Bundle of the fetch, register-file and execute handshake signals seen by id_stage.
// Optional feature macro: ID_ILLEGAL_DET_EN adds ID_EX_illegal_o to the bundle.
interface id_stage_if #(
    parameter int BITSIZE = 32
);
    // Fetch -> decode instruction handoff
    logic               IF_ID_give_i;
    logic [31:0]        IF_ID_instr_i;
    logic [BITSIZE-1:0] IF_ID_pc_i;
    logic               ID_IF_get_o;
    // Combinational register-file read ports
    logic [4:0]         ID_RF_rs1_addr_o;
    logic [4:0]         ID_RF_rs2_addr_o;
    logic [BITSIZE-1:0] RF_ID_rs1_data_i;
    logic [BITSIZE-1:0] RF_ID_rs2_data_i;
    // Decode -> execute handoff
    logic               EX_ID_get_i;
    logic               ID_EX_give_o;
    logic [BITSIZE-1:0] ID_EX_pc_o;
    logic [BITSIZE-1:0] ID_EX_rs1_data_o;
    logic [BITSIZE-1:0] ID_EX_rs2_data_o;
    logic [BITSIZE-1:0] ID_EX_imm_o;
    logic [4:0]         ID_EX_rd_o;
    logic [6:0]         ID_EX_opcode_o;
    logic [2:0]         ID_EX_funct3_o;
    logic               ID_EX_funct7b5_o;
    logic               ID_EX_rd_we_o;
    // Flush request from a resolved branch
    logic               branch_taken_i;
`ifdef ID_ILLEGAL_DET_EN
    logic               ID_EX_illegal_o;

    modport slave (
        input  IF_ID_give_i, IF_ID_instr_i, IF_ID_pc_i, RF_ID_rs1_data_i, RF_ID_rs2_data_i,
               EX_ID_get_i, branch_taken_i,
        output ID_IF_get_o, ID_RF_rs1_addr_o, ID_RF_rs2_addr_o, ID_EX_give_o, ID_EX_pc_o,
               ID_EX_rs1_data_o, ID_EX_rs2_data_o, ID_EX_imm_o, ID_EX_rd_o, ID_EX_opcode_o,
               ID_EX_funct3_o, ID_EX_funct7b5_o, ID_EX_rd_we_o, ID_EX_illegal_o
    );
    modport master (
        output IF_ID_give_i, IF_ID_instr_i, IF_ID_pc_i, RF_ID_rs1_data_i, RF_ID_rs2_data_i,
               EX_ID_get_i, branch_taken_i,
        input  ID_IF_get_o, ID_RF_rs1_addr_o, ID_RF_rs2_addr_o, ID_EX_give_o, ID_EX_pc_o,
               ID_EX_rs1_data_o, ID_EX_rs2_data_o, ID_EX_imm_o, ID_EX_rd_o, ID_EX_opcode_o,
               ID_EX_funct3_o, ID_EX_funct7b5_o, ID_EX_rd_we_o, ID_EX_illegal_o
    );
`else
    modport slave (
        input  IF_ID_give_i, IF_ID_instr_i, IF_ID_pc_i, RF_ID_rs1_data_i, RF_ID_rs2_data_i,
               EX_ID_get_i, branch_taken_i,
        output ID_IF_get_o, ID_RF_rs1_addr_o, ID_RF_rs2_addr_o, ID_EX_give_o, ID_EX_pc_o,
               ID_EX_rs1_data_o, ID_EX_rs2_data_o, ID_EX_imm_o, ID_EX_rd_o, ID_EX_opcode_o,
               ID_EX_funct3_o, ID_EX_funct7b5_o, ID_EX_rd_we_o
    );
    modport master (
        output IF_ID_give_i, IF_ID_instr_i, IF_ID_pc_i, RF_ID_rs1_data_i, RF_ID_rs2_data_i,
               EX_ID_get_i, branch_taken_i,
        input  ID_IF_get_o, ID_RF_rs1_addr_o, ID_RF_rs2_addr_o, ID_EX_give_o, ID_EX_pc_o,
               ID_EX_rs1_data_o, ID_EX_rs2_data_o, ID_EX_imm_o, ID_EX_rd_o, ID_EX_opcode_o,
               ID_EX_funct3_o, ID_EX_funct7b5_o, ID_EX_rd_we_o
    );
`endif
endinterface

// File: rtl/id_stage.sv
// RV32I instruction decode stage: accepts one instruction from fetch, reads the
// register file for one cycle, then presents the decoded bundle to execute.
// Optional feature macro: ID_ILLEGAL_DET_EN flags opcodes outside RV32I.
module id_stage #(
    parameter int BITSIZE = 32
) (
    input  logic       clk,
    input  logic       resetn_i,
    id_stage_if.slave  bus
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        WAIT_INSTR = 2'd0,
        DECODE     = 2'd1,
        PROVIDE    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_get;
    logic               w_give;
    logic [4:0]         w_rs1_addr;
    logic [4:0]         w_rs2_addr;
    logic               w_if_xfer;

    logic [31:0]        r_instr;
    logic [BITSIZE-1:0] r_pc;
    logic [BITSIZE-1:0] r_pc_out;
    logic [BITSIZE-1:0] r_rs1_data;
    logic [BITSIZE-1:0] r_rs2_data;
    logic [BITSIZE-1:0] r_imm;
    logic [4:0]         r_rd;
    logic [6:0]         r_opcode;
    logic [2:0]         r_funct3;
    logic               r_funct7b5;
    logic               r_rd_we;
`ifdef ID_ILLEGAL_DET_EN
    logic               r_illegal;
`endif

    // Sign-extended immediate selected by instruction format; R-type and unknown give 0
    function automatic logic [BITSIZE-1:0] imm_gen(input logic [31:0] instr);
        logic [31:0] v_imm;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: v_imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:  v_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: v_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: v_imm = {instr[31:12], 12'h000};
            OP_JAL:    v_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default:   v_imm = 32'h0000_0000;
        endcase
        return BITSIZE'($signed(v_imm));
    endfunction

    // True when the encoding is outside the supported RV32I opcode set
    function automatic logic is_illegal(input logic [31:0] instr);
        logic v_known;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
            OP_JAL, OP_REG, OP_FENCE, OP_SYSTEM: v_known = 1'b1;
            default:                             v_known = 1'b0;
        endcase
        return (!v_known) || (instr[1:0] != 2'b11);
    endfunction

    // Register write enable: stores, branches and x0 never write back
    function automatic logic rd_we_gen(input logic [31:0] instr);
        logic v_we;
        v_we = (instr[6:0] != OP_STORE) && (instr[6:0] != OP_BRANCH) &&
               (instr[11:7] != 5'd0);
`ifdef ID_ILLEGAL_DET_EN
        v_we = v_we && !is_illegal(instr);
`endif
        return v_we;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= WAIT_INSTR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state, handshakes and RF addressing; a flush overrides everything
    always_comb begin
        w_next_state = r_state;
        w_get        = 1'b0;
        w_give       = 1'b0;
        w_rs1_addr   = 5'd0;
        w_rs2_addr   = 5'd0;
        case (r_state)
            WAIT_INSTR: begin
                w_get = 1'b1;
                if (bus.IF_ID_give_i) begin
                    w_next_state = DECODE;
                end else begin
                    w_next_state = WAIT_INSTR;
                end
            end
            DECODE: begin
                w_rs1_addr   = r_instr[19:15];
                w_rs2_addr   = r_instr[24:20];
                w_next_state = PROVIDE;
            end
            PROVIDE: begin
                w_give = bus.EX_ID_get_i;
                if (bus.EX_ID_get_i) begin
                    w_next_state = WAIT_INSTR;
                end else begin
                    w_next_state = PROVIDE;
                end
            end
            default: begin
                w_next_state = WAIT_INSTR;
            end
        endcase
        if (bus.branch_taken_i) begin
            w_next_state = WAIT_INSTR;
            w_give       = 1'b0;
        end else begin
            w_give       = w_give;
        end
    end

    assign w_if_xfer = (r_state == WAIT_INSTR) && bus.IF_ID_give_i && !bus.branch_taken_i;

    // Instruction latch on IF transfer and decoded-bundle capture in DECODE
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            r_instr    <= 32'h0000_0000;
            r_pc       <= '0;
            r_pc_out   <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= 5'd0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_rd_we    <= 1'b0;
`ifdef ID_ILLEGAL_DET_EN
            r_illegal  <= 1'b0;
`endif
        end else if (bus.branch_taken_i) begin
            r_instr    <= 32'h0000_0000;
            r_pc       <= '0;
            r_pc_out   <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= 5'd0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_rd_we    <= 1'b0;
`ifdef ID_ILLEGAL_DET_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            if (w_if_xfer) begin
                r_instr <= bus.IF_ID_instr_i;
                r_pc    <= bus.IF_ID_pc_i;
            end
            if (r_state == DECODE) begin
                r_pc_out   <= r_pc;
                r_rs1_data <= bus.RF_ID_rs1_data_i;
                r_rs2_data <= bus.RF_ID_rs2_data_i;
                r_imm      <= imm_gen(r_instr);
                r_rd       <= r_instr[11:7];
                r_opcode   <= r_instr[6:0];
                r_funct3   <= r_instr[14:12];
                r_funct7b5 <= r_instr[30];
                r_rd_we    <= rd_we_gen(r_instr);
`ifdef ID_ILLEGAL_DET_EN
                r_illegal  <= is_illegal(r_instr);
`endif
            end
        end
    end

    // Handshake outputs are forced low while reset is asserted
    assign bus.ID_IF_get_o      = w_get & resetn_i;
    assign bus.ID_EX_give_o     = w_give & resetn_i;
    assign bus.ID_RF_rs1_addr_o = w_rs1_addr;
    assign bus.ID_RF_rs2_addr_o = w_rs2_addr;
    assign bus.ID_EX_pc_o       = r_pc_out;
    assign bus.ID_EX_rs1_data_o = r_rs1_data;
    assign bus.ID_EX_rs2_data_o = r_rs2_data;
    assign bus.ID_EX_imm_o      = r_imm;
    assign bus.ID_EX_rd_o       = r_rd;
    assign bus.ID_EX_opcode_o   = r_opcode;
    assign bus.ID_EX_funct3_o   = r_funct3;
    assign bus.ID_EX_funct7b5_o = r_funct7b5;
    assign bus.ID_EX_rd_we_o    = r_rd_we;
`ifdef ID_ILLEGAL_DET_EN
    assign bus.ID_EX_illegal_o  = r_illegal;
`endif
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected decode bundles are queued when an
// instruction is handed over and compared when execute receives a give.
module tb_id_stage;
    logic clk;
    logic resetn_i;
    int   n_checks;
    int   n_errors;
    int   last_wait;
    logic [31:0] last_imm;
    logic        last_we;

    id_stage_if #(.BITSIZE(32)) bus ();

    id_stage #(.BITSIZE(32)) u_dut (
        .clk      (clk),
        .resetn_i (resetn_i),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: distinct data per address
    function automatic logic [31:0] rf1(input logic [4:0] a);
        return 32'hC0DE_0000 + 32'(a) * 32'd17;
    endfunction
    function automatic logic [31:0] rf2(input logic [4:0] a);
        return 32'h5EED_0000 + 32'(a) * 32'd33;
    endfunction
    assign bus.RF_ID_rs1_data_i = rf1(bus.ID_RF_rs1_addr_o);
    assign bus.RF_ID_rs2_data_i = rf2(bus.ID_RF_rs2_addr_o);

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic legal;
        e.pc = pc;
        e.rs1 = rf1(i[19:15]);
        e.rs2 = rf2(i[24:20]);
        e.rd = i[11:7];
        e.op = i[6:0];
        e.f3 = i[14:12];
        e.f7 = i[30];
        legal = (i[1:0] == 2'b11);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: e.imm = {{20{i[31]}}, i[31:20]};
            7'h23: e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63: e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: e.imm = {i[31:12], 12'h000};
            7'h6F: e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: e.imm = 32'h0;
        endcase
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h33, 7'h0F, 7'h73: legal = legal;
            default: legal = 1'b0;
        endcase
        e.ill = !legal;
        e.we = (i[6:0] != 7'h23) && (i[6:0] != 7'h63) && (i[11:7] != 5'd0);
`ifdef ID_ILLEGAL_DET_EN
        e.we = e.we && legal;
`endif
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Hand over one instruction at the current negedge; returns at the DECODE negedge
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bit push);
        check_eq("if_get", bus.ID_IF_get_o, 1);
        bus.IF_ID_give_i  = 1'b1;
        bus.IF_ID_instr_i = instr;
        bus.IF_ID_pc_i    = pc;
        @(negedge clk);
        bus.IF_ID_give_i  = 1'b0;
        bus.IF_ID_instr_i = 32'hDEAD_BEEF;
        if (push) sb_q.push_back(model(instr, pc));
        check_eq("decode_give", bus.ID_EX_give_o, 0);
        check_eq("decode_get", bus.ID_IF_get_o, 0);
        check_eq("rs1_addr", bus.ID_RF_rs1_addr_o, 32'(instr[19:15]));
        check_eq("rs2_addr", bus.ID_RF_rs2_addr_o, 32'(instr[24:20]));
    endtask

    // Wait (bounded) for a give, compare against the scoreboard head, step past it
    task automatic collect();
        exp_t e;
        int waited;
        waited = 0;
        while (!bus.ID_EX_give_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        check_eq("give_seen", bus.ID_EX_give_o, 1);
        if (bus.ID_EX_give_o) begin
            check_eq("sb_nonempty", sb_q.size(), 32'(sb_q.size() > 0 ? sb_q.size() : 1));
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("pc", bus.ID_EX_pc_o, e.pc);
                check_eq("rs1_data", bus.ID_EX_rs1_data_o, e.rs1);
                check_eq("rs2_data", bus.ID_EX_rs2_data_o, e.rs2);
                check_eq("imm", bus.ID_EX_imm_o, e.imm);
                check_eq("rd", bus.ID_EX_rd_o, 32'(e.rd));
                check_eq("opcode", bus.ID_EX_opcode_o, 32'(e.op));
                check_eq("funct3", bus.ID_EX_funct3_o, 32'(e.f3));
                check_eq("funct7b5", bus.ID_EX_funct7b5_o, 32'(e.f7));
                check_eq("rd_we", bus.ID_EX_rd_we_o, 32'(e.we));
`ifdef ID_ILLEGAL_DET_EN
                check_eq("illegal", bus.ID_EX_illegal_o, 32'(e.ill));
`endif
            end
            last_imm = bus.ID_EX_imm_o;
            last_we  = bus.ID_EX_rd_we_o;
        end
        @(negedge clk);
        check_eq("back_to_wait_get", bus.ID_IF_get_o, 1);
        check_eq("back_to_wait_give", bus.ID_EX_give_o, 0);
    endtask

    logic [31:0] tbl [12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        tbl[0]  = 32'h123450B7; tbl[1]  = 32'hFFFFF117; tbl[2]  = 32'h0040006F;
        tbl[3]  = 32'hFFDFF0EF; tbl[4]  = 32'h00B50533; tbl[5]  = 32'hFFC52283;
        tbl[6]  = 32'h000080E7; tbl[7]  = 32'h40535293; tbl[8]  = 32'h0000007F;
        tbl[9]  = 32'h000000FF; tbl[10] = 32'h80000013; tbl[11] = 32'h00000093;
        resetn_i = 1'b0;
        bus.IF_ID_give_i = 1'b0;
        bus.IF_ID_instr_i = 32'h0;
        bus.IF_ID_pc_i = 32'h0;
        bus.EX_ID_get_i = 1'b1;
        bus.branch_taken_i = 1'b0;
        #1;
        check_eq("rst_get", bus.ID_IF_get_o, 0);
        check_eq("rst_give", bus.ID_EX_give_o, 0);
        check_eq("rst_imm", bus.ID_EX_imm_o, 0);
        check_eq("rst_rd_we", bus.ID_EX_rd_we_o, 0);
        @(negedge clk);
        @(negedge clk);
        resetn_i = 1'b1;
        #1;
        check_eq("post_rst_get", bus.ID_IF_get_o, 1);
        @(negedge clk);

        // ADDI with latency check, then SW and BEQ
        send(32'hFFF00093, 32'h10, 1'b1);
        @(negedge clk);
        collect();
        check_eq("addi_latency", last_wait, 0);
        check_eq("addi_imm", last_imm, 32'hFFFF_FFFF);
        send(32'h00112223, 32'h14, 1'b1);
        @(negedge clk);
        collect();
        check_eq("sw_imm", last_imm, 32'h0000_0004);
        check_eq("sw_we", last_we, 0);
        send(32'hFE000EE3, 32'h18, 1'b1);
        @(negedge clk);
        collect();
        check_eq("beq_imm", last_imm, 32'hFFFF_FFFC);
        check_eq("beq_we", last_we, 0);

        // Format and boundary sweep
        for (int k = 0; k < 12; k++) begin
            send(tbl[k], 32'h100 + 32'(k) * 32'd4, 1'b1);
            @(negedge clk);
            collect();
        end
        check_eq("x7f_we", last_we, 1);

        // Backpressure: five stalled cycles then a single give
        bus.EX_ID_get_i = 1'b0;
        send(32'h00A00513, 32'h200, 1'b1);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_give", bus.ID_EX_give_o, 0);
            check_eq("bp_get", bus.ID_IF_get_o, 0);
            check_eq("bp_imm", bus.ID_EX_imm_o, 32'h0000_000A);
            check_eq("bp_pc", bus.ID_EX_pc_o, 32'h200);
            @(negedge clk);
        end
        bus.EX_ID_get_i = 1'b1;
        #1;
        collect();

        // Flush during DECODE drops the instruction
        send(32'h00500593, 32'h300, 1'b0);
        bus.branch_taken_i = 1'b1;
        #1;
        check_eq("flush_dec_give", bus.ID_EX_give_o, 0);
        @(negedge clk);
        bus.branch_taken_i = 1'b0;
        check_eq("flush_dec_get", bus.ID_IF_get_o, 1);
        check_eq("flush_dec_imm", bus.ID_EX_imm_o, 0);
        check_eq("flush_dec_pc", bus.ID_EX_pc_o, 0);
        check_eq("flush_dec_rs1", bus.ID_EX_rs1_data_o, 0);
        check_eq("flush_dec_rd", bus.ID_EX_rd_o, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("flush_no_give", bus.ID_EX_give_o, 0);
        end

        // Flush during PROVIDE masks give in the same cycle
        bus.EX_ID_get_i = 1'b0;
        send(32'h00700613, 32'h310, 1'b0);
        @(negedge clk);
        bus.EX_ID_get_i = 1'b1;
        bus.branch_taken_i = 1'b1;
        #1;
        check_eq("flush_prv_give", bus.ID_EX_give_o, 0);
        @(negedge clk);
        bus.branch_taken_i = 1'b0;
        check_eq("flush_prv_get", bus.ID_IF_get_o, 1);
        check_eq("flush_prv_imm", bus.ID_EX_imm_o, 0);

        // IF transfer coinciding with a flush is dropped
        bus.IF_ID_give_i = 1'b1;
        bus.IF_ID_instr_i = 32'h00900693;
        bus.branch_taken_i = 1'b1;
        @(negedge clk);
        bus.IF_ID_give_i = 1'b0;
        bus.branch_taken_i = 1'b0;
        check_eq("drop_get", bus.ID_IF_get_o, 1);
        check_eq("drop_rs1_addr", bus.ID_RF_rs1_addr_o, 0);
        send(32'h00B00713, 32'h320, 1'b1);
        @(negedge clk);
        collect();

        // Asynchronous reset in PROVIDE between edges
        bus.EX_ID_get_i = 1'b0;
        send(32'hFFF00793, 32'h400, 1'b0);
        @(negedge clk);
        #2;
        resetn_i = 1'b0;
        #1;
        check_eq("arst_get", bus.ID_IF_get_o, 0);
        check_eq("arst_imm", bus.ID_EX_imm_o, 0);
        check_eq("arst_pc", bus.ID_EX_pc_o, 0);
        check_eq("arst_op", bus.ID_EX_opcode_o, 0);
        bus.EX_ID_get_i = 1'b1;
        #1;
        check_eq("arst_give", bus.ID_EX_give_o, 0);
        @(negedge clk);
        resetn_i = 1'b1;
        #1;
        check_eq("arst_release_get", bus.ID_IF_get_o, 1);
        send(32'h00D00813, 32'h500, 1'b1);
        @(negedge clk);
        collect();
        check_eq("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
